// File: rtl/core_pkg.sv
// Shared core types for the multiply/divide unit: op and state encodings,
// the funct7 decode constant, and operand-signedness helpers.
package core_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  // MULHSU treats only rs1 as signed.
  function automatic logic op_a_signed(input muldiv_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            flush_i;
  logic            ready_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, funct3_i, op_a_i, op_b_i, flush_i,
    input  ready_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, funct3_i, op_a_i, op_b_i, flush_i,
    output ready_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/muldiv_iter_dp.sv
// One-bit-per-cycle shift-add multiply / restoring divide datapath over unsigned
// magnitudes. With MULDIV_FAST_MUL_EN defined only the divide step remains.
module muldiv_iter_dp #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              step,
  input  logic              mode,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
);

  // hi_reg is the product high half or partial remainder; lo_reg holds the
  // multiplier bits being consumed or the dividend bits becoming quotient.
  logic [XLEN-1:0] hi_reg, hi_next;
  logic [XLEN-1:0] lo_reg, lo_next;
  logic [XLEN-1:0] b_reg;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

`ifdef MULDIV_FAST_MUL_EN
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    shifted = {hi_reg, lo_reg[XLEN-1]};
    diff    = shifted - {1'b0, b_reg};
    if (step) begin
      hi_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_next = {lo_reg[XLEN-2:0], ~diff[XLEN]};
    end
  end
`else
  logic [XLEN:0] sum;

  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    shifted = {hi_reg, lo_reg[XLEN-1]};
    diff    = shifted - {1'b0, b_reg};
    sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    if (step) begin
      if (mode) begin
        // A borrow out of the trial subtraction means the divisor did not fit.
        hi_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        lo_next = {lo_reg[XLEN-2:0], ~diff[XLEN]};
      end else begin
        hi_next = sum[XLEN:1];
        lo_next = {sum[0], lo_reg[XLEN-1:1]};
      end
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_reg <= '0;
      lo_reg <= '0;
      b_reg  <= '0;
    end else if (load) begin
      hi_reg <= '0;
      lo_reg <= mag_a;
      b_reg  <= mag_b;
    end else if (step) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
    end
  end

  assign prod = {hi_reg, lo_reg};
  assign quot = lo_reg;
  assign rem  = hi_reg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: FSM, counter, sign and special-case
// handling. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_unit
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [1:0] ST_IDLE = MD_IDLE;
  localparam logic [1:0] ST_CALC = MD_CALC;
  localparam logic [1:0] ST_DONE = MD_DONE;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  muldiv_op_e       op_reg;
  logic             neg_reg;
  logic             direct_reg;
  logic [XLEN-1:0]  res_reg;

  muldiv_op_e      req_op;
  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic            neg_flag;
  logic [XLEN-1:0] special_res;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;
  logic            direct_hit;
  logic [XLEN-1:0] direct_val;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  assign req_op = muldiv_op_e'(bus.funct3_i);
  assign accept = bus.valid_i & (state_reg == ST_IDLE) & ~bus.flush_i;
  assign a_neg  = op_a_signed(req_op) & bus.op_a_i[XLEN-1];
  assign b_neg  = op_b_signed(req_op) & bus.op_b_i[XLEN-1];
  assign mag_a  = a_neg ? -bus.op_a_i : bus.op_a_i;
  assign mag_b  = b_neg ? -bus.op_b_i : bus.op_b_i;

  assign div_zero = op_is_div(req_op) & (bus.op_b_i == '0);
  assign div_ovf  = op_is_div(req_op) & op_a_signed(req_op) &
                    (bus.op_a_i == MOST_NEG) & (bus.op_b_i == '1);

  // Remainders follow the dividend's sign; quotients and products the XOR.
  assign neg_flag = (op_is_div(req_op) & req_op[1]) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = req_op[1] ? bus.op_a_i : '1;
    end else if (div_ovf) begin
      special_res = req_op[1] ? '0 : MOST_NEG;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extending to 2*XLEN gives the same low 2*XLEN bits as an
  // (XLEN+1)x(XLEN+1) signed product, which is all either half needs.
  logic signed [2*XLEN-1:0] sext_a, sext_b, fast_prod;
  assign sext_a    = {{XLEN{a_neg}}, bus.op_a_i};
  assign sext_b    = {{XLEN{b_neg}}, bus.op_b_i};
  assign fast_prod = sext_a * sext_b;
  assign fast_hit  = ~op_is_div(req_op);
  assign fast_res  = (req_op == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  assign direct_hit = div_zero | div_ovf | fast_hit;
  assign direct_val = (div_zero | div_ovf) ? special_res : fast_res;

  muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (accept),
    .step  (state_reg == ST_CALC),
    .mode  (op_is_div(op_reg)),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .prod  (prod),
    .quot  (quot),
    .rem   (rem)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      op_reg     <= MD_MUL;
      neg_reg    <= 1'b0;
      direct_reg <= 1'b0;
      res_reg    <= '0;
    end else if (bus.flush_i) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            cnt_reg    <= '0;
            op_reg     <= req_op;
            neg_reg    <= neg_flag;
            direct_reg <= direct_hit;
            res_reg    <= direct_val;
            state_reg  <= direct_hit ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(XLEN - 1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  logic [XLEN-1:0]   div_val;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   iter_res;

  always_comb begin
    div_val     = op_reg[1] ? rem : quot;
    prod_signed = neg_reg ? -prod : prod;
    iter_res    = '0;
    if (op_is_div(op_reg)) begin
      iter_res = neg_reg ? -div_val : div_val;
    end else if (op_reg == MD_MUL) begin
      iter_res = prod_signed[XLEN-1:0];
    end else begin
      iter_res = prod_signed[2*XLEN-1:XLEN];
    end
  end

  assign bus.ready_o  = (state_reg == ST_IDLE);
  assign bus.busy_o   = ~bus.ready_o;
  assign bus.valid_o  = (state_reg == ST_DONE) & ~bus.flush_i;
  assign bus.result_o = bus.valid_o ? (direct_reg ? res_reg : iter_res) : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed cases, flush and
// asynchronous reset scenarios, then randomized ops against an arithmetic model.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension results computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op < 3'd4) return MUL_LAT;
    if (b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    logic [31:0] got;
    int          lat;
    int          cyc;
    bit          seen;
    exp  = ref_result(op, a, b);
    lat  = ref_latency(op, a, b);
    got  = '0;
    seen = 1'b0;
    @(negedge clk);
    check({tag, " ready_before"}, bus.ready_o, 1'b1);
    bus.valid_i  = 1'b1;
    bus.funct3_i = op;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    cyc = 1;
    if (lat > 1) begin
      check({tag, " busy_c1"}, {bus.ready_o, bus.busy_o}, 2'b01);
      check({tag, " result_idle"}, bus.result_o, 32'd0);
    end
    while (!seen && cyc <= 100) begin
      if (bus.valid_o) begin
        seen = 1'b1;
        got  = bus.result_o;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    check({tag, " valid_seen"}, seen, 1'b1);
    check({tag, " result"}, got, exp);
    check({tag, " latency"}, cyc, lat);
    $display("op=%0d a=%h b=%h result=%h expected=%h cycle=%0d [%s]", op, a, b, got, exp, cyc, tag);
    @(posedge clk);
    #1;
    check({tag, " ready_after"}, {bus.ready_o, bus.valid_o}, 2'b10);
  endtask

  initial begin
    bit saw_valid;
    bit seen;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.funct3_i  = 3'd0;
    bus.op_a_i    = '0;
    bus.op_b_i    = '0;
    bus.flush_i   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset ready/busy", {bus.ready_o, bus.busy_o}, 2'b10);
    check("reset valid", bus.valid_o, 1'b0);
    check("reset result", bus.result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");

    run_op("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0",     3'd5, 32'h0000_1234, 32'd0);
    run_op("remu_by0",     3'd7, 32'h0000_1234, 32'd0);
    run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mulhsu_ones",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu_ones",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_ones",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_by0",      3'd4, 32'hFFFF_FFF9, 32'd0);
    run_op("divu_nonovf",  3'd5, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush at cycle 10 of a DIVU: no result, idle at cycle 11.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.funct3_i = 3'd5; bus.op_a_i = 32'd100; bus.op_b_i = 32'd7;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    saw_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      saw_valid |= bus.valid_o;
      @(posedge clk);
      #1;
    end
    bus.flush_i = 1'b1;
    #1;
    saw_valid |= bus.valid_o;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check("flush_calc no_valid", saw_valid, 1'b0);
    check("flush_calc ready_c11", {bus.ready_o, bus.valid_o}, 2'b10);
    $display("flush during CALC at cycle 10");
    run_op("divu_after_flush", 3'd5, 32'd100, 32'd7);

    // Flush landing in the DONE cycle suppresses the strobe.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.funct3_i = 3'd5; bus.op_a_i = 32'd100; bus.op_b_i = 32'd7;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      if (bus.valid_o) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("flush_done reached", seen, 1'b1);
    bus.flush_i = 1'b1;
    #1;
    check("flush_done valid", bus.valid_o, 1'b0);
    check("flush_done result", bus.result_o, 32'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check("flush_done ready", {bus.ready_o, bus.valid_o}, 2'b10);
    $display("flush during DONE");

    // Request together with flush in IDLE is dropped.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.flush_i = 1'b1;
    bus.funct3_i = 3'd0; bus.op_a_i = 32'd3; bus.op_b_i = 32'd5;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    check("flush_idle dropped", {bus.ready_o, bus.valid_o}, 2'b10);
    $display("request with flush in IDLE");

    // Asynchronous reset between edges in CALC.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.funct3_i = 3'd7; bus.op_a_i = 32'd100; bus.op_b_i = 32'd7;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst ready/busy", {bus.ready_o, bus.busy_o}, 2'b10);
    check("async_rst valid", bus.valid_o, 1'b0);
    #1;
    rst = 1'b0;
    $display("asynchronous reset mid-CALC");
    run_op("remu_after_rst", 3'd7, 32'd100, 32'd7);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          kind;
      op   = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      kind = $urandom_range(0, 9);
      if (kind == 0) b = 32'd0;
      else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (kind == 2) b = 32'($urandom_range(1, 15));
      else if (kind == 3) a = 32'($urandom_range(0, 255));
      run_op("random", op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M/RV64M multiply-divide unit in the EX stage, beside the ALU. It takes operands and a `funct3` op code when its decoder sees `funct7 = 0000001` on an OP instruction. The result arrives several cycles later through a valid/ready handshake, and the hazard unit holds the pipeline while `busy_o` is high. It adds multi-cycle, width-parametrised arithmetic that the single-cycle ALU path cannot provide.

## Interface
- `XLEN`, 32: operand/result width; 32 or 64.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `valid_i` in 1: request valid; sampled only when `ready_o`=1.
- `funct3_i` in 3: operation, `muldiv_op_e` encoding.
- `op_a_i` in XLEN: rs1 value.
- `op_b_i` in XLEN: rs2 value.
- `flush_i` in 1: abort any in-flight operation (branch mispredict or trap).
- `ready_o` out 1: idle and able to accept.
- `busy_o` out 1: operation in flight; equals `~ready_o`.
- `valid_o` out 1: one-cycle result strobe.
- `result_o` out XLEN: result; valid only while `valid_o`=1, otherwise 0.

## Operation
- Ops by `funct3`:
  - 0 MUL (low XLEN bits); 1 MULH (s×s high); 2 MULHSU (s×u high); 3 MULHU (u×u high).
  - 4 DIV; 5 DIVU; 6 REM; 7 REMU.
- Accept on `valid_i & ready_o & ~flush_i`.
  - Latch op, operand magnitudes, result-sign flag and negate flag.
  - Signedness per op: MULHSU treats only A as signed.
- States:
  - IDLE → CALC on a normal accept.
  - IDLE → DONE on a special-case or fast-multiply accept.
  - CALC → DONE when the iteration counter reaches XLEN.
  - DONE → IDLE unconditionally.
- Multiply (iterative): shift-add over magnitudes into a 2·XLEN accumulator, 1 bit/cycle. Negate the 2·XLEN product if the signs differ, then select the low or high half.
- Divide: restoring shift-subtract, 1 quotient bit/cycle.
  - Quotient takes the XOR of the operand signs.
  - Remainder takes the dividend's sign.
- Special cases resolve in the accept cycle; no iteration:
  - Divisor 0: DIV/DIVU → all-ones; REM/REMU → dividend.
  - Signed overflow (A = most-negative, B = −1): DIV → most-negative; REM → 0.
- Counter: $clog2(XLEN+1) bits; cleared on accept.
- No output backpressure. EX consumes `result_o` in the `valid_o` cycle.

## Timing
- Reset values: state IDLE, `ready_o`=1, `busy_o`=0, `valid_o`=0, `result_o`=0, counter 0. Applies asynchronously, including mid-operation.
- Latency, accept at cycle 0:
  - Iterative ops: `valid_o` at cycle XLEN+1.
  - Special cases and fast MUL*: `valid_o` at cycle 1.
- `ready_o` falls the cycle after accept and rises the cycle after `valid_o`. Throughput is one op per latency+1 cycles.
- `flush_i` in any state: IDLE next cycle; `valid_o` stays 0, including when the flush lands in the DONE cycle.
- `flush_i` together with `valid_i` in IDLE: request dropped.
- `valid_i` while busy: ignored. The requester holds its request.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle (XLEN+1)×(XLEN+1) signed multiplier, registered in DONE.
  - Latency 1; the CALC multiply path is removed.
- Undefined: all multiplies iterate, latency XLEN+1. Division is identical in both builds.

## Structure
- Shared package `core_pkg`:
  - `muldiv_op_e` (3-bit, values 0–7 as above).
  - `muldiv_state_e` (IDLE, CALC, DONE).
  - `FUNCT7_MULDIV` = 7'b0000001.
- Sub-module `muldiv_iter_dp`: per-cycle shift-add/shift-subtract datapath (accumulator, remainder, quotient registers) with a `mode` (mul/div) and a `step` enable. The top level holds the FSM, counter, sign handling and special-case logic.

## Test plan
- MULH 0x80000000 × 0x80000000 (XLEN=32) → `result_o`=0x40000000 at cycle 33; with `MULDIV_FAST_MUL_EN`, at cycle 1.
- DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; each at cycle 33.
- Special cases:
  - DIVU 0x1234 / 0 → 0xFFFFFFFF at cycle 1.
  - REMU 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU same → 0xFFFFFFFE; MUL same → 0x00000001.
- DIVU 100/7, `flush_i` at cycle 10 → no `valid_o`, `ready_o`=1 at cycle 11; a following DIVU 100/7 → 14 at its own cycle 33.
- `rst_i` pulsed mid-CALC (asynchronous, between edges) → `ready_o`=1 and `valid_o`=0 immediately; a subsequent REMU 100/7 → 2.
